filter_env_alpha: RTL and testbench
===================================

# filter_env_alpha

Cutoff-envelope generator directly upstream of the EWMA low-pass filter: produces the filter's 9-bit signed `s_alpha` coefficient from a gate using an attack/decay/sustain/release (ADSR) envelope. The envelope advances once per sample tick. The output is linearly mapped into a programmable `[alpha_min, alpha_max]` window, which gives per-note filter sweeps.

## Interface
Parameters:
- `ACC_BITS`, default 16: envelope accumulator width; must be ≥ 16.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous and active-high.
- `sample_tick` in 1: one-cycle strobe at sample rate; the envelope steps only on this strobe.
- `gate` in 1: note gate.
- `a_rate` in 8: attack increment per tick; 0 means instant.
- `d_rate` in 8: decay decrement per tick; 0 means instant.
- `s_level` in 8: sustain level.
- `r_rate` in 8: release decrement per tick; 0 means instant.
- `alpha_min` in 8: alpha at envelope 0 (unsigned).
- `alpha_max` in 8: alpha at envelope full scale (unsigned). It may be less than `alpha_min`, which gives an inverted sweep.
- `s_alpha` out 9, signed: coefficient for the filter; bit 8 is always 0.
- `env_state` out 3: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.

## Operation
- State is `acc[ACC_BITS-1:0]`; `env8 = acc[ACC_BITS-1:ACC_BITS-8]`.
- Targets:
  - FULL = all ones.
  - SUS = `{s_level, zeros}`.
- Rate values are zero-extended and added or subtracted at the `acc` LSB.
- Gate edges are detected against a registered copy `gate_q`:
  - Rising edge (`gate && !gate_q`), in any state → ATTACK. `acc` is kept, so retrigger starts from the current level.
  - Gate low while in ATTACK, DECAY or SUSTAIN → RELEASE.
  - IDLE with gate low: no action.
- Tick behaviour per state (on `sample_tick`, when no gate transition occurs this cycle):
  - IDLE: `acc` holds.
  - ATTACK: `acc += a_rate`, saturating at FULL. If `a_rate == 0`, or `acc` reaches FULL, then `acc = FULL` and state → DECAY.
  - DECAY: `acc -= d_rate`. If the result is ≤ SUS, or `d_rate == 0`, then `acc = SUS` and state → SUSTAIN.
  - SUSTAIN: `acc = SUS` on every tick, so `s_level` changes are followed on the next tick.
  - RELEASE: `acc -= r_rate`. If the result is ≤ 0, or `r_rate == 0`, then `acc = 0` and state → IDLE.
- Priority: a gate transition in the same cycle as `sample_tick` wins. State changes and `acc` does not step that cycle.
- Mapping, computed every cycle:
  - `env9 = env8 + env8[7]` (range 0..256).
  - `span = alpha_max - alpha_min`, 9-bit signed.
  - `s_alpha = alpha_min + ((span * env9) >>> 8)`, using an 18-bit signed product.
  - The result is always within `[min(alpha_min, alpha_max), max(alpha_min, alpha_max)]`.
  - Envelope 0 gives exactly `alpha_min`; FULL gives exactly `alpha_max`.

## Timing
- Reset values: `acc = 0`, `env_state = IDLE`, `gate_q = 0`, `s_alpha = 0`.
- Reset asserted mid-envelope forces these values at the next edge, regardless of gate or tick.
- State and `acc` update on the edge that samples `sample_tick` or the gate transition.
- `s_alpha` is registered. It reflects `acc` and the `alpha_*` inputs with one clock of latency after `acc` changes.
- Changes to `alpha_min`/`alpha_max` alone also appear one cycle later.
- `env_state` is the state register itself (zero latency).
- There is no handshake: `sample_tick` may be asserted on every cycle.
- Gate edges are honoured on any cycle, not only on tick cycles.

## Configuration
- `FILTER_ENV_ALPHA_LOOP_EN` defined:
  - Adds input `loop` (1 bit).
  - When `loop = 1` and gate is high, entering SUSTAIN immediately re-enters ATTACK on the next tick. This gives an LFO-like repeating sweep.
  - Gate low still goes to RELEASE.
- Undefined: no `loop` port; SUSTAIN holds while the gate is high.

## Test plan
1. Reset check: reset with arbitrary inputs → `env_state=0`, `s_alpha=0`. The first cycle after reset, with `alpha_min=16` → `s_alpha=16`.
2. Attack timing: `ACC_BITS=16`, `alpha_min=16`, `alpha_max=200`, `a_rate=255`, tick every cycle, gate raised → DECAY entered after exactly 257 ticks (255·257 = 0xFFFF). `s_alpha=200` one cycle after `acc=0xFFFF`.
3. Instant decay into sustain: continue with `d_rate=0`, `s_level=128` → on the next tick, `acc=0x8000`, SUSTAIN, and `s_alpha = 16 + (184·129>>8) = 108`.
4. Release timing: drop gate with `r_rate=128` → RELEASE immediately. IDLE after 256 ticks, then `s_alpha=16`.
5. Retrigger and priority: regate mid-release at `acc=0x4000` in the same cycle as a tick → ATTACK, and `acc` stays 0x4000 on that edge. Separately, assert `rst` mid-attack → IDLE, `acc=0`.
6. Inverted window: `alpha_min=200`, `alpha_max=16`, envelope at FULL → `s_alpha=16`; at 0 → `s_alpha=200`. With `FILTER_ENV_ALPHA_LOOP_EN` and `loop=1`, the state cycles ATTACK→DECAY→SUSTAIN→ATTACK while gate is held.

Source files
------------

// File: rtl/filter_env_alpha.sv
// ADSR cutoff envelope mapped linearly into an [alpha_min, alpha_max] window for the EWMA filter.
// Latency: state/acc update on the tick or gate edge; s_alpha registered, one cycle behind acc.
// Backpressure: none; sample_tick may strobe every cycle. FILTER_ENV_ALPHA_LOOP_EN adds the loop input.
module filter_env_alpha #(
    parameter int ACC_BITS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_tick,
    input  logic              gate,
    input  logic [7:0]        a_rate,
    input  logic [7:0]        d_rate,
    input  logic [7:0]        s_level,
    input  logic [7:0]        r_rate,
    input  logic [7:0]        alpha_min,
    input  logic [7:0]        alpha_max,
`ifdef FILTER_ENV_ALPHA_LOOP_EN
    input  logic              loop,
`endif
    output logic signed [8:0] s_alpha,
    output logic [2:0]        env_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    localparam logic [ACC_BITS-1:0] FULL = {ACC_BITS{1'b1}};

    env_state_t          state_q, state_d;
    logic [ACC_BITS-1:0] acc_q, acc_d;
    logic                gate_q, gate_d;
    logic [8:0]          s_alpha_q, s_alpha_d;

    logic [ACC_BITS-1:0] sus;
    logic [ACC_BITS:0]   att_ext;
    logic [ACC_BITS:0]   dec_ext;
    logic [ACC_BITS:0]   rel_ext;
    logic                gate_rise;
    logic                loop_on;

    logic [7:0]          env8;
    logic [8:0]          env9;
    logic [8:0]          span;
    logic [17:0]         prod;
    logic                unused_prod;

    // Sustain target and one-bit-wider step results so carry/borrow flag saturation.
    always_comb begin
        sus       = {s_level, {(ACC_BITS-8){1'b0}}};
        att_ext   = {1'b0, acc_q} + {{(ACC_BITS-7){1'b0}}, a_rate};
        dec_ext   = {1'b0, acc_q} - {{(ACC_BITS-7){1'b0}}, d_rate};
        rel_ext   = {1'b0, acc_q} - {{(ACC_BITS-7){1'b0}}, r_rate};
        gate_rise = gate && !gate_q;
`ifdef FILTER_ENV_ALPHA_LOOP_EN
        loop_on   = loop;
`else
        loop_on   = 1'b0;
`endif
    end

    // State, accumulator, gate history and registered coefficient.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            gate_q    <= 1'b0;
            s_alpha_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            gate_q    <= gate_d;
            s_alpha_q <= s_alpha_d;
        end
    end

    // Next state: gate transitions take priority over the tick; acc only steps on a quiet tick.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        gate_d  = gate;
        if (gate_rise) begin
            state_d = ATTACK;
        end else if (!gate && (state_q inside {ATTACK, DECAY, SUSTAIN})) begin
            state_d = RELEASE;
        end else if (sample_tick) begin
            unique case (state_q)
                IDLE: begin
                    acc_d = acc_q;
                end
                ATTACK: begin
                    if ((a_rate == 8'd0) || att_ext[ACC_BITS] || (att_ext[ACC_BITS-1:0] == FULL)) begin
                        acc_d   = FULL;
                        state_d = DECAY;
                    end else begin
                        acc_d = att_ext[ACC_BITS-1:0];
                    end
                end
                DECAY: begin
                    if ((d_rate == 8'd0) || dec_ext[ACC_BITS] || (dec_ext[ACC_BITS-1:0] <= sus)) begin
                        acc_d   = sus;
                        state_d = SUSTAIN;
                    end else begin
                        acc_d = dec_ext[ACC_BITS-1:0];
                    end
                end
                SUSTAIN: begin
                    // Tracks s_level every tick; in loop mode the next tick restarts the attack.
                    acc_d = sus;
                    if (loop_on) begin
                        state_d = ATTACK;
                    end
                end
                RELEASE: begin
                    if ((r_rate == 8'd0) || rel_ext[ACC_BITS] || (rel_ext[ACC_BITS-1:0] == '0)) begin
                        acc_d   = '0;
                        state_d = IDLE;
                    end else begin
                        acc_d = rel_ext[ACC_BITS-1:0];
                    end
                end
                default: begin
                    acc_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output mapping: env9 reaches 256 at full scale so the window end is hit exactly.
    always_comb begin
        env8 = acc_q[ACC_BITS-1 -: 8];
        env9 = {1'b0, env8} + {8'b0, env8[7]};
        span = {1'b0, alpha_max} - {1'b0, alpha_min};
        // Low 18 bits of an unsigned multiply equal the signed product; |product| < 2^16.
        prod = {{9{span[8]}}, span} * {9'b0, env9};
        // prod[16:8] is the arithmetic >>> 8 result, which always fits in 9 signed bits.
        s_alpha_d   = {1'b0, alpha_min} + prod[16:8];
        unused_prod = ^{prod[17], prod[7:0]};
    end

    assign s_alpha   = s_alpha_q;
    assign env_state = state_q;

endmodule

// File: tb/tb_filter_env_alpha.sv
// Self-checking bench for filter_env_alpha: directed ADSR scenarios, then randomized traffic.
// Reference model is an integer ADSR envelope stepped once per clock alongside the DUT.
// Outputs are sampled 1 time unit after each rising edge.
module tb_filter_env_alpha;

    logic              clk = 1'b0;
    logic              rst;
    logic              sample_tick;
    logic              gate;
    logic [7:0]        a_rate, d_rate, s_level, r_rate, alpha_min, alpha_max;
    logic              loop;
    logic signed [8:0] s_alpha;
    logic [2:0]        env_state;

    int total = 0;
    int bad   = 0;

    // model state
    int m_acc = 0;
    int m_st  = 0;
    int m_gq  = 0;
    int m_alpha = 0;

    localparam int FULL = 65535;
`ifdef FILTER_ENV_ALPHA_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    filter_env_alpha #(.ACC_BITS(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .gate        (gate),
        .a_rate      (a_rate),
        .d_rate      (d_rate),
        .s_level     (s_level),
        .r_rate      (r_rate),
        .alpha_min   (alpha_min),
        .alpha_max   (alpha_max),
`ifdef FILTER_ENV_ALPHA_LOOP_EN
        .loop        (loop),
`endif
        .s_alpha     (s_alpha),
        .env_state   (env_state)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int map_alpha(input int acc, input int amin, input int amax);
        int e8, e9;
        e8 = acc / 256;
        e9 = e8 + ((e8 >= 128) ? 1 : 0);
        return amin + (((amax - amin) * e9) >>> 8);
    endfunction

    // Advance one clock: predict from the pre-edge inputs, then compare after the edge.
    task automatic step();
        int nacc, nst, nalpha, t, sus;
        nacc   = m_acc;
        nst    = m_st;
        sus    = int'(s_level) * 256;
        nalpha = map_alpha(m_acc, int'(alpha_min), int'(alpha_max));
        if (gate && (m_gq == 0)) begin
            nst = 1;
        end else if (!gate && (m_st == 1 || m_st == 2 || m_st == 3)) begin
            nst = 4;
        end else if (sample_tick) begin
            case (m_st)
                1: begin
                    if (a_rate == 0 || m_acc + int'(a_rate) >= FULL) begin
                        nacc = FULL; nst = 2;
                    end else nacc = m_acc + int'(a_rate);
                end
                2: begin
                    t = m_acc - int'(d_rate);
                    if (d_rate == 0 || t <= sus) begin
                        nacc = sus; nst = 3;
                    end else nacc = t;
                end
                3: begin
                    nacc = sus;
                    if (LOOP_EN && loop) nst = 1;
                end
                4: begin
                    t = m_acc - int'(r_rate);
                    if (r_rate == 0 || t <= 0) begin
                        nacc = 0; nst = 0;
                    end else nacc = t;
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_acc = 0; m_st = 0; m_gq = 0; m_alpha = 0;
        end else begin
            m_acc = nacc; m_st = nst; m_gq = int'(gate); m_alpha = nalpha;
        end
        chk("state", int'(env_state), m_st);
        chk("alpha", int'(s_alpha), m_alpha);
        chk("acc", int'(dut.acc_q), m_acc);
    endtask

    initial begin
        int n, saw, prev;
        rst = 1'b1; sample_tick = 1'b1; gate = 1'b1; loop = 1'b0;
        a_rate = 8'($urandom); d_rate = 8'($urandom); s_level = 8'($urandom);
        r_rate = 8'($urandom); alpha_min = 8'($urandom); alpha_max = 8'($urandom);
        repeat (3) step();
        chk("rst_state", int'(env_state), 0);
        chk("rst_alpha", int'(s_alpha), 0);

        rst = 1'b0; gate = 1'b0; sample_tick = 1'b0;
        alpha_min = 8'd16; alpha_max = 8'd200;
        step();
        chk("post_rst_alpha", int'(s_alpha), 16);

        // attack timing
        a_rate = 8'd255; d_rate = 8'd0; s_level = 8'd128; sample_tick = 1'b1; gate = 1'b1;
        step();
        chk("attack_enter", int'(env_state), 1);
        n = 0;
        while (env_state == 3'd1 && n < 400) begin step(); n++; end
        chk("attack_ticks", n, 257);
        chk("acc_full", int'(dut.acc_q), 65535);
        step();
        chk("alpha_full", int'(s_alpha), 200);
        chk("sus_state", int'(env_state), 3);
        chk("sus_acc", int'(dut.acc_q), 32768);
        step();
        chk("sus_alpha", int'(s_alpha), 108);

        // release timing
        gate = 1'b0; r_rate = 8'd128;
        step();
        chk("rel_enter", int'(env_state), 4);
        n = 0;
        while (env_state == 3'd4 && n < 400) begin step(); n++; end
        chk("rel_ticks", n, 256);
        step();
        chk("idle_alpha", int'(s_alpha), 16);

        // retrigger mid-release, then reset mid-attack
        a_rate = 8'd0; gate = 1'b1;
        repeat (3) step();
        gate = 1'b0;
        step();
        repeat (128) step();
        chk("rel_mid_acc", int'(dut.acc_q), 16384);
        gate = 1'b1;
        step();
        chk("retrig_state", int'(env_state), 1);
        chk("retrig_acc", int'(dut.acc_q), 16384);
        a_rate = 8'd10;
        repeat (5) step();
        rst = 1'b1;
        step();
        chk("rst_mid_state", int'(env_state), 0);
        chk("rst_mid_acc", int'(dut.acc_q), 0);
        rst = 1'b0; gate = 1'b0;
        step();

        // inverted window
        alpha_min = 8'd200; alpha_max = 8'd16; a_rate = 8'd0; gate = 1'b1;
        repeat (2) step();
        sample_tick = 1'b0;
        step();
        chk("inv_full", int'(s_alpha), 16);
        gate = 1'b0;
        step();
        r_rate = 8'd0; sample_tick = 1'b1;
        repeat (2) step();
        chk("inv_zero", int'(s_alpha), 200);

`ifdef FILTER_ENV_ALPHA_LOOP_EN
        loop = 1'b1; a_rate = 8'd64; d_rate = 8'd64; s_level = 8'd100; gate = 1'b1;
        saw = 0; prev = int'(env_state);
        for (int i = 0; i < 3000 && saw < 3; i++) begin
            step();
            if (prev == 3 && env_state == 3'd1) saw++;
            prev = int'(env_state);
        end
        chk("loop_restarts", saw, 3);
        loop = 1'b0; gate = 1'b0;
        step();
`endif

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            sample_tick = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) gate = ~gate;
            if ($urandom_range(0, 149) == 0) a_rate = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if ($urandom_range(0, 149) == 0) d_rate = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if ($urandom_range(0, 149) == 0) r_rate = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if ($urandom_range(0, 99) == 0) s_level = 8'($urandom);
            if ($urandom_range(0, 99) == 0) alpha_min = 8'($urandom);
            if ($urandom_range(0, 99) == 0) alpha_max = 8'($urandom);
            if ($urandom_range(0, 199) == 0) loop = 1'($urandom_range(0, 1));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
